instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instr_enc_pkg.sv | 46 ++++
 rtl/instr_field_pack.sv | 53 +++++
 rtl/instruction_encoder.sv | 89 ++++++++
 tb/tb_instruction_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared constants, format enum and immediate range helper for the instruction encoder.
package instr_enc_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_S,
    FMT_SB,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [63:0] imm;
  } req_t;

  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    fmt_e fmt;
    unique case (opcode)
      OP_LOAD:   fmt = FMT_I;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_SB;
      default:   fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

  // True when imm[63:msb] are all copies of the sign bit.
  function automatic logic sext_fits(input logic [63:0] imm, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i >= msb && imm[i] != imm[63]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of request fields into an I/S/SB instruction word, with range checking.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [63:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e fmt;
  logic fits_12;
  logic fits_13;

  assign fmt     = decode_fmt(opcode);
  assign fits_12 = sext_fits(imm, 11);
  assign fits_13 = sext_fits(imm, 12);

  always_comb begin
    instr = NOP;
    err   = 1'b1;
    unique case (fmt)
      FMT_I: begin
        if (fits_12) begin
          instr = {imm[11:0], rs1, funct3, rd, opcode};
          err   = 1'b0;
        end
      end
      FMT_S: begin
        if (fits_12) begin
          instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
          err   = 1'b0;
        end
      end
      FMT_SB: begin
        // Branch offsets are halfword aligned, so bit 0 is never encoded.
        if (fits_13 && !imm[0]) begin
          instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
          err   = 1'b0;
        end
      end
      default: begin
        instr = NOP;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready pipeline around instr_field_pack with saturating handshake counters.
module instruction_encoder
  import instr_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  req_t        s1_req;
  logic        s1_valid;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic        s1_adv;
  logic        s2_adv;
  logic        out_hs;
  logic [31:0] pk_instr;
  logic        pk_err;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = rst_n && s1_adv;
  assign out_hs    = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;

  instr_field_pack u_pack (
    .opcode (s1_req.opcode),
    .rd     (s1_req.rd),
    .rs1    (s1_req.rs1),
    .rs2    (s1_req.rs2),
    .funct3 (s1_req.funct3),
    .imm    (s1_req.imm),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_req    <= '0;
      s2_valid  <= 1'b0;
      s2_instr  <= '0;
      s2_err    <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_req <= '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      funct3: in_funct3, imm: in_imm};
        end
      end
      // Stage 2 payload only moves when it is actually replaced, so it holds under backpressure.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= pk_instr;
          s2_err   <= pk_err;
        end
      end
      if (out_hs) begin
        if (enc_count != CNT_MAX) enc_count <= enc_count + 1'b1;
        if (s2_err && err_count != CNT_MAX) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder; a second instance with CNT_W=4 covers counter saturation.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [15:0] enc_count, err_count;

  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_instr4;
  logic [3:0]  enc_count4, err_count4;

  always #5 clk = ~clk;

  instruction_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  instruction_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid4),
    .out_ready(out_ready), .out_instr(out_instr4), .out_err(out_err4),
    .enc_count(enc_count4), .err_count(err_count4)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          accepted;
  bit          holding;
  bit          lat_flag;
  bit          rand_ready;
  logic [31:0] held_instr;
  logic        held_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    exp_t e;
    logic signed [63:0] s;
    s = $signed(imm);
    e.instr = 32'h0000_0013;
    e.err   = 1'b1;
    e.acc   = 0;
    e.lat   = 1'b0;
    case (op)
      7'b0000011: if (s >= -2048 && s <= 2047) begin
        e.instr = {imm[11:0], rs1, f3, rd, op};
        e.err   = 1'b0;
      end
      7'b0100011: if (s >= -2048 && s <= 2047) begin
        e.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        e.err   = 1'b0;
      end
      7'b1100011: if (s >= -4096 && s <= 4095 && imm[0] == 1'b0) begin
        e.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e.err   = 1'b0;
      end
      default: ;
    endcase
    return e;
  endfunction

  // One cycle: evaluate just after the falling edge, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    accepted = 1'b0;
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && !out_valid) check_val("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (holding) begin
          check_val("hold_instr", out_instr, held_instr);
          check_val("hold_err", out_err, held_err);
        end
        if (out_ready) begin
          holding = 1'b0;
          if (sbq.size() == 0) begin
            check_val("unexpected_out", out_valid, 0);
          end else begin
            e = sbq.pop_front();
            check_val("instr", out_instr, e.instr);
            check_val("err", out_err, e.err);
            if (e.lat) check_val("latency", cyc - e.acc, 2);
          end
        end else begin
          holding    = 1'b1;
          held_instr = out_instr;
          held_err   = out_err;
        end
      end else begin
        holding = 1'b0;
      end
      if (in_valid && in_ready) begin
        e = model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        e.acc = cyc;
        e.lat = lat_flag;
        sbq.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                      input bit lat);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    lat_flag  = lat;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check_val("accept_timeout", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c0;
    int v;
    logic [6:0] ops[4];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b1100011; ops[3] = 7'b0110011;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_imm = '0; out_ready = 1'b1; rand_ready = 1'b0; lat_flag = 1'b0;
    holding = 1'b0; accepted = 1'b0;
    @(negedge clk);
    idle(3);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_instr", out_instr, 0);
    check_val("rst_out_err", out_err, 0);
    check_val("rst_enc_count", enc_count, 0);
    check_val("rst_err_count", err_count, 0);
    check_val("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    idle(1);
    check_val("in_ready_idle", in_ready, 1);

    send(7'b0000011, 5, 2, 0, 3, -64'sd8, 1); idle(3);
    send(7'b0100011, 0, 2, 5, 3, 64'd16, 1); idle(3);
    send(7'b1100011, 0, 1, 2, 0, -64'sd4, 1); idle(3);

    send(7'b1100011, 0, 1, 2, 0, 64'd3, 1); idle(3);
    send(7'b0000011, 5, 2, 0, 3, 64'd2048, 1); idle(3);
    send(7'b0110011, 1, 2, 3, 0, 64'd0, 1); idle(3);
    check_val("err_count_3", err_count, 3);
    check_val("enc_count_6", enc_count, 6);

    send(7'b0000011, 1, 2, 0, 0, 64'd2047, 0);
    send(7'b0000011, 1, 2, 0, 0, -64'sd2048, 0);
    send(7'b1100011, 0, 3, 4, 1, 64'd4094, 0);
    send(7'b1100011, 0, 3, 4, 1, -64'sd4096, 0);
    send(7'b1100011, 0, 3, 4, 1, 64'd4096, 0);
    send(7'b0100011, 0, 3, 4, 2, -64'sd2049, 0);
    send(7'b1100011, 0, 3, 4, 1, 64'd2, 0);
    idle(4);
    check_val("enc_count_13", enc_count, 13);
    check_val("err_count_5", err_count, 5);

    out_ready = 1'b0;
    send(7'b0000011, 7, 8, 0, 2, 64'd100, 0);
    send(7'b0100011, 0, 9, 10, 2, -64'sd100, 0);
    check_val("bp_in_ready", in_ready, 0);
    in_valid = 1'b1; in_opcode = 7'b1100011; in_rs1 = 11; in_rs2 = 12; in_funct3 = 1; in_imm = 64'd40;
    tick();
    check_val("bp_no_accept", accepted, 0);
    out_ready = 1'b1;
    send(7'b1100011, 0, 11, 12, 1, 64'd40, 0);
    send(7'b0000011, 13, 14, 0, 4, -64'sd1, 0);
    idle(4);
    check_val("bp_enc_count", enc_count, 17);

    c0 = cyc;
    for (int i = 0; i < 8; i++) send(7'b0000011, 5'(i), 5'(i + 1), 0, 3'(i), 64'(i * 4), 1);
    check_val("throughput", cyc - c0, 8);
    idle(4);
    check_val("enc_count_25", enc_count, 25);

    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 10000)) - 5000;
      send(ops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
           {{32{v[31]}}, v}, 0);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(5);
    check_val("drain_random", sbq.size(), 0);

    out_ready = 1'b0;
    send(7'b0000011, 1, 1, 0, 0, 64'd1, 0);
    send(7'b0000011, 2, 2, 0, 0, 64'd2, 0);
    rst_n = 1'b0;
    idle(1);
    check_val("rst_full_out_valid", out_valid, 0);
    check_val("rst_full_enc_count", enc_count, 0);
    check_val("rst_full_err_count", err_count, 0);
    check_val("rst_full_in_ready", in_ready, 0);
    sbq.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(7'b0100011, 0, 2, 5, 3, 64'd16, 1);
    idle(3);
    check_val("post_rst_enc_count", enc_count, 1);

    for (int i = 0; i < 20; i++) send(7'b0100011, 0, 5'(i), 5'(i + 2), 3'(i), 64'(i), 0);
    idle(4);
    check_val("enc_count_21", enc_count, 21);
    check_val("sat_enc_count4", enc_count4, 15);
    send(7'b0000011, 3, 4, 0, 1, 64'd8, 0);
    send(7'b0000011, 3, 4, 0, 1, 64'd9, 0);
    idle(4);
    check_val("sat_hold_enc_count4", enc_count4, 15);
    check_val("enc_count_23", enc_count, 23);
    check_val("final_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
